// File: rtl/boid_display_scheduler_if.sv
// Signal bundle between the display scheduler and its neighbours (VGA, BPU array,
// display RAM and CPU taps). The master modport is the scheduler side.
interface boid_display_scheduler_if #(
  parameter int MAX_BOIDS      = 4,
  parameter int BITS_FOR_BOIDS = $clog2(MAX_BOIDS),
  parameter int ADDR_W         = 20
);
  logic                      screen_end;
  logic [BITS_FOR_BOIDS-1:0] boid_sel;
  logic [ADDR_W-1:0]         boid_addr;
  logic                      ram_switch;
  logic                      disp_we;
  logic [ADDR_W-1:0]         disp_addr;
  logic                      cpu_we;
  logic [BITS_FOR_BOIDS-1:0] cpu_idx;
  logic [9:0]                cpu_x;
  logic [8:0]                cpu_y;
  logic [MAX_BOIDS-1:0]      bpu_we;
  logic [9:0]                bpu_x;
  logic [8:0]                bpu_y;
  logic                      busy;
  logic                      overrun;
  logic                      cpu_drop;

  modport master (
    input  screen_end, boid_addr, cpu_we, cpu_idx, cpu_x, cpu_y,
    output boid_sel, ram_switch, disp_we, disp_addr, bpu_we, bpu_x, bpu_y,
           busy, overrun, cpu_drop
  );

  modport slave (
    output screen_end, boid_addr, cpu_we, cpu_idx, cpu_x, cpu_y,
    input  boid_sel, ram_switch, disp_we, disp_addr, bpu_we, bpu_x, bpu_y,
           busy, overrun, cpu_drop
  );
endinterface

// File: rtl/boid_display_scheduler.sv
// Per-frame display RAM refresh sequencer with CPU-to-BPU write arbitration.
// Optional feature macro: BOID_BOUNDS_CHECK_EN (suppress writes to addresses >= PIXEL_COUNT).
module boid_display_scheduler #(
  parameter int MAX_BOIDS      = 4,
  parameter int BITS_FOR_BOIDS = $clog2(MAX_BOIDS),
  parameter int PIXEL_COUNT    = 307200,
  parameter int ADDR_W         = 20
) (
  input logic clock,
  input logic CPU_RESETN,
  boid_display_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SWITCH = 2'd1,
    S_SCAN   = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  localparam logic [BITS_FOR_BOIDS-1:0] LAST_IDX   = BITS_FOR_BOIDS'(MAX_BOIDS - 1);
  localparam logic [ADDR_W-1:0]         ADDR_LIMIT = ADDR_W'(PIXEL_COUNT);
`ifdef BOID_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [BITS_FOR_BOIDS-1:0] r_idx;
  logic                      r_ram_switch;
  logic                      r_disp_we;
  logic [ADDR_W-1:0]         r_disp_addr;
  logic                      r_overrun;
  logic                      r_pend_vld;
  logic [BITS_FOR_BOIDS-1:0] r_pend_idx;
  logic [9:0]                r_pend_x;
  logic [8:0]                r_pend_y;
  logic                      r_cpu_drop;
  logic                      w_idle;
  logic                      w_replay;
  logic                      w_addr_ok;
  logic [MAX_BOIDS-1:0]      w_bpu_we;
  logic [9:0]                w_bpu_x;
  logic [8:0]                w_bpu_y;

  function automatic logic [MAX_BOIDS-1:0] f_onehot(input logic [BITS_FOR_BOIDS-1:0] idx);
    logic [MAX_BOIDS-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_BOIDS; i++) begin
      if (idx == BITS_FOR_BOIDS'(i)) begin
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

  assign w_idle    = (r_state == S_IDLE);
  assign w_replay  = w_idle && r_pend_vld;
  assign w_addr_ok = (bus.boid_addr < ADDR_LIMIT) || !BOUNDS_EN;

  // Frame sequencer next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.screen_end) begin
          w_state_nxt = S_SWITCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SWITCH: w_state_nxt = S_SCAN;
      S_SCAN: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_SCAN;
        end
      end
      S_DRAIN: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Frame sequencer state, scan index and display RAM write port
  always_ff @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_ram_switch <= 1'b0;
      r_disp_we    <= 1'b0;
      r_disp_addr  <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ram_switch <= w_idle && bus.screen_end;
      // Index rests at 0 outside SCAN so the read mux sees boid 0 when idle.
      if (r_state == S_SCAN) begin
        r_idx       <= (r_idx == LAST_IDX) ? '0 : r_idx + BITS_FOR_BOIDS'(1);
        r_disp_addr <= bus.boid_addr;
        r_disp_we   <= w_addr_ok;
      end else begin
        r_idx     <= '0;
        r_disp_we <= 1'b0;
      end
      if (!w_idle && bus.screen_end) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // CPU write steering: replayed entry first, then pass-through, else nothing
  always_comb begin
    w_bpu_we = '0;
    w_bpu_x  = '0;
    w_bpu_y  = '0;
    if (w_replay) begin
      w_bpu_we = f_onehot(r_pend_idx);
      w_bpu_x  = r_pend_x;
      w_bpu_y  = r_pend_y;
    end else if (w_idle && bus.cpu_we) begin
      w_bpu_we = f_onehot(bus.cpu_idx);
      w_bpu_x  = bus.cpu_x;
      w_bpu_y  = bus.cpu_y;
    end else begin
      w_bpu_we = '0;
    end
  end

  // One-entry pending buffer; the slot frees in the replay cycle so a same-cycle request fits
  always_ff @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_pend_vld <= 1'b0;
      r_pend_idx <= '0;
      r_pend_x   <= '0;
      r_pend_y   <= '0;
      r_cpu_drop <= 1'b0;
    end else begin
      if (bus.cpu_we && !(w_idle && !r_pend_vld)) begin
        if (!r_pend_vld || w_replay) begin
          r_pend_vld <= 1'b1;
          r_pend_idx <= bus.cpu_idx;
          r_pend_x   <= bus.cpu_x;
          r_pend_y   <= bus.cpu_y;
        end else begin
          r_cpu_drop <= 1'b1;
        end
      end else if (w_replay) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign bus.boid_sel   = r_idx;
  assign bus.ram_switch = r_ram_switch;
  assign bus.disp_we    = r_disp_we;
  assign bus.disp_addr  = r_disp_addr;
  assign bus.busy       = !w_idle;
  assign bus.overrun    = r_overrun;
  assign bus.cpu_drop   = r_cpu_drop;
  assign bus.bpu_we     = w_bpu_we;
  assign bus.bpu_x      = w_bpu_x;
  assign bus.bpu_y      = w_bpu_y;

endmodule

// File: tb/tb_boid_display_scheduler.sv
// Scoreboard bench for boid_display_scheduler: expected RAM writes and BPU writes are
// queued by the stimulus and popped by independent negedge monitors.
module tb_boid_display_scheduler;
  localparam int MB = 4;
  localparam int BB = 2;
  localparam int AW = 20;

  logic clock = 1'b0;
  logic CPU_RESETN;
  always #5 clock = ~clock;

  boid_display_scheduler_if #(.MAX_BOIDS(MB), .BITS_FOR_BOIDS(BB), .ADDR_W(AW)) bus ();

  boid_display_scheduler #(
    .MAX_BOIDS(MB), .BITS_FOR_BOIDS(BB), .PIXEL_COUNT(307200), .ADDR_W(AW)
  ) dut (
    .clock(clock),
    .CPU_RESETN(CPU_RESETN),
    .bus(bus)
  );

  logic [AW-1:0] addrs [MB];
  assign bus.boid_addr = addrs[bus.boid_sel];

  int total = 0;
  int bad = 0;
  logic [AW-1:0] exp_disp [$];
  logic [22:0]   exp_bpu [$];
  logic [AW-1:0] mon_d;
  logic [22:0]   mon_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < MB; i++) exp_disp.push_back(addrs[i]);
  endtask

  always @(negedge clock) begin
    if (bus.disp_we === 1'b1) begin
      total++;
      if (exp_disp.size() == 0) begin
        bad++;
        $display("FAIL disp_unexpected: got addr %0d expected no write", bus.disp_addr);
      end else begin
        mon_d = exp_disp.pop_front();
        if (bus.disp_addr !== mon_d) begin
          bad++;
          $display("FAIL disp_addr: got %0d expected %0d", bus.disp_addr, mon_d);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (bus.bpu_we !== 4'b0000) begin
      total++;
      if (exp_bpu.size() == 0) begin
        bad++;
        $display("FAIL bpu_unexpected: got we=%b x=%0d y=%0d expected no write",
                 bus.bpu_we, bus.bpu_x, bus.bpu_y);
      end else begin
        mon_b = exp_bpu.pop_front();
        if ({bus.bpu_we, bus.bpu_x, bus.bpu_y} !== mon_b) begin
          bad++;
          $display("FAIL bpu_write: got we=%b x=%0d y=%0d expected we=%b x=%0d y=%0d",
                   bus.bpu_we, bus.bpu_x, bus.bpu_y, mon_b[22:19], mon_b[18:9], mon_b[8:0]);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_switch"}, 32'(bus.ram_switch), 32'd0);
    check({tag, "_disp_we"},    32'(bus.disp_we),    32'd0);
    check({tag, "_disp_addr"},  32'(bus.disp_addr),  32'd0);
    check({tag, "_busy"},       32'(bus.busy),       32'd0);
    check({tag, "_boid_sel"},   32'(bus.boid_sel),   32'd0);
    check({tag, "_overrun"},    32'(bus.overrun),    32'd0);
    check({tag, "_cpu_drop"},   32'(bus.cpu_drop),   32'd0);
    check({tag, "_bpu_we"},     32'(bus.bpu_we),     32'd0);
  endtask

  initial begin
    CPU_RESETN     = 1'b0;
    bus.screen_end = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_idx    = 2'd0;
    bus.cpu_x      = 10'd0;
    bus.cpu_y      = 9'd0;
    addrs[0] = 20'd10; addrs[1] = 20'd6410; addrs[2] = 20'd100; addrs[3] = 20'd307199;

    repeat (2) tick();
    @(negedge clock);
    check_reset_outputs("reset");
    tick();
    CPU_RESETN = 1'b1;
    tick();

    // Basic frame: switch at T+1, writes T+3..T+6, idle at T+7
    push_frame();
    bus.screen_end = 1'b1;
    tick();
    bus.screen_end = 1'b0;
    @(negedge clock);
    check("f1_ram_switch", 32'(bus.ram_switch), 32'd1);
    check("f1_busy", 32'(bus.busy), 32'd1);
    tick();
    @(negedge clock);
    check("f1_sel0", 32'(bus.boid_sel), 32'd0);
    check("f1_we_t2", 32'(bus.disp_we), 32'd0);
    check("f1_ram_switch_t2", 32'(bus.ram_switch), 32'd0);
    for (int i = 0; i < MB; i++) begin
      tick();
      @(negedge clock);
      check("f1_disp_we", 32'(bus.disp_we), 32'd1);
      check("f1_sel", 32'(bus.boid_sel), (i < MB - 1) ? 32'(i + 1) : 32'd0);
    end
    tick();
    @(negedge clock);
    check("f1_busy_end", 32'(bus.busy), 32'd0);
    check("f1_we_end", 32'(bus.disp_we), 32'd0);
    check("f1_queue", 32'(exp_disp.size()), 32'd0);

    // Overrun: second screen_end at T+4 is ignored
    tick();
    push_frame();
    bus.screen_end = 1'b1;
    tick();
    bus.screen_end = 1'b0;
    repeat (3) tick();
    bus.screen_end = 1'b1;
    tick();
    bus.screen_end = 1'b0;
    repeat (4) tick();
    @(negedge clock);
    check("ovr_flag", 32'(bus.overrun), 32'd1);
    check("ovr_busy", 32'(bus.busy), 32'd0);
    check("ovr_queue", 32'(exp_disp.size()), 32'd0);

    // Pass-through CPU write in IDLE
    tick();
    bus.cpu_we = 1'b1; bus.cpu_idx = 2'd2; bus.cpu_x = 10'd320; bus.cpu_y = 9'd240;
    exp_bpu.push_back({4'b0100, 10'd320, 9'd240});
    @(negedge clock);
    check("pt_bpu_we", 32'(bus.bpu_we), 32'd4);
    check("pt_bpu_x", 32'(bus.bpu_x), 32'd320);
    check("pt_bpu_y", 32'(bus.bpu_y), 32'd240);
    tick();
    bus.cpu_we = 1'b0;

    // Buffered write during scan, second one dropped, replay in first idle cycle
    push_frame();
    bus.screen_end = 1'b1;
    tick();
    bus.screen_end = 1'b0;
    tick();
    bus.cpu_we = 1'b1; bus.cpu_idx = 2'd2; bus.cpu_x = 10'd320; bus.cpu_y = 9'd240;
    exp_bpu.push_back({4'b0100, 10'd320, 9'd240});
    @(negedge clock);
    check("buf_bpu_we_t2", 32'(bus.bpu_we), 32'd0);
    tick();
    bus.cpu_idx = 2'd1; bus.cpu_x = 10'd5; bus.cpu_y = 9'd6;
    @(negedge clock);
    check("buf_bpu_we_t3", 32'(bus.bpu_we), 32'd0);
    tick();
    bus.cpu_we = 1'b0;
    @(negedge clock);
    check("drop_flag", 32'(bus.cpu_drop), 32'd1);
    repeat (2) tick();
    @(negedge clock);
    check("buf_busy_t6", 32'(bus.busy), 32'd1);
    check("buf_bpu_we_t6", 32'(bus.bpu_we), 32'd0);
    tick();
    @(negedge clock);
    check("rep_busy", 32'(bus.busy), 32'd0);
    check("rep_bpu_we", 32'(bus.bpu_we), 32'd4);
    check("rep_bpu_x", 32'(bus.bpu_x), 32'd320);
    tick();
    @(negedge clock);
    check("rep_after", 32'(bus.bpu_we), 32'd0);

    // Replay collides with a new request: pending first, new one next cycle
    push_frame();
    bus.screen_end = 1'b1;
    tick();
    bus.screen_end = 1'b0;
    tick();
    bus.cpu_we = 1'b1; bus.cpu_idx = 2'd0; bus.cpu_x = 10'd1; bus.cpu_y = 9'd2;
    exp_bpu.push_back({4'b0001, 10'd1, 9'd2});
    tick();
    bus.cpu_we = 1'b0;
    repeat (4) tick();
    bus.cpu_we = 1'b1; bus.cpu_idx = 2'd3; bus.cpu_x = 10'd7; bus.cpu_y = 9'd8;
    exp_bpu.push_back({4'b1000, 10'd7, 9'd8});
    @(negedge clock);
    check("col_first", 32'(bus.bpu_we), 32'd1);
    tick();
    bus.cpu_we = 1'b0;
    @(negedge clock);
    check("col_second", 32'(bus.bpu_we), 32'd8);
    check("col_second_y", 32'(bus.bpu_y), 32'd8);
    tick();
    @(negedge clock);
    check("col_done", 32'(bus.bpu_we), 32'd0);

    // Out-of-range address slot
    addrs[1] = 20'd400000;
    exp_disp.push_back(addrs[0]);
`ifndef BOID_BOUNDS_CHECK_EN
    exp_disp.push_back(addrs[1]);
`endif
    exp_disp.push_back(addrs[2]);
    exp_disp.push_back(addrs[3]);
    bus.screen_end = 1'b1;
    tick();
    bus.screen_end = 1'b0;
    repeat (6) tick();
    @(negedge clock);
    check("bnd_busy", 32'(bus.busy), 32'd0);
    check("bnd_queue", 32'(exp_disp.size()), 32'd0);
    addrs[1] = 20'd6410;

    // Reset mid-scan at T+4: only boid 0 was written
    tick();
    exp_disp.push_back(addrs[0]);
    bus.screen_end = 1'b1;
    tick();
    bus.screen_end = 1'b0;
    repeat (3) tick();
    CPU_RESETN = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) tick();
    CPU_RESETN = 1'b1;
    repeat (10) tick();
    @(negedge clock);
    check("final_disp_queue", 32'(exp_disp.size()), 32'd0);
    check("final_bpu_queue", 32'(exp_bpu.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
